if_stage: RTL and testbench

- Instruction-fetch stage of the multi-cycle MIPS-style CPU.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register (IR) and presents IR fields to decode.
- Its imme[15:0] output feeds the immediate sign extender directly; opcode/rs/rt/rd/shamt/funct/target feed control and the register file.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/ir_fields.sv | 26 ++
 rtl/if_stage.sv | 169 ++++++++++++++++
 tb/tb_if_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, instruction width,
// default fetch reset address and the fetch-stage state encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;

  // Instruction field bit positions (MIPS-style R/I/J formats)
  localparam int OP_HI     = 31;
  localparam int OP_LO     = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FAULT is only reachable when the misalignment check is built in
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    FAULT = 2'd3
  } if_state_t;

endpackage

// File: rtl/ir_fields.sv
// Pure combinational slicing of an instruction word into its decode fields.
// Shared by the fetch stage and later decode logic.
module ir_fields
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imme,
  output logic [25:0]        target
);

  assign opcode = ir[OP_HI:OP_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign shamt  = ir[SHAMT_HI:SHAMT_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imme   = ir[IMM_HI:IMM_LO];
  assign target = ir[TARGET_HI:TARGET_LO];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests over a
// req/ack handshake, latches the returned word into IR and presents its
// fields to decode. Redirects that arrive while a request is outstanding are
// held pending so the request is never withdrawn before its ack.
// Optional build macro IF_MISALIGN_CHECK_EN adds fetch_fault and a FAULT
// state entered on a misaligned redirect target; without it the low two
// target bits are simply cleared.
module if_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               ir_ready,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imme,
  output logic [25:0]        target
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic               fetch_fault
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  if_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic               pend_reg, pend_next;
  logic [ADDR_W-1:0]  pend_pc_reg, pend_pc_next;

  // Word-aligned targets; the raw low bits are kept in pend_pc_reg so the
  // misalignment check can still see them when the pending redirect lands.
  logic [ADDR_W-1:0]  redir_tgt, pend_tgt;
  logic               redir_bad, pend_bad;

  assign redir_tgt = redirect_pc & ALIGN_MASK;
  assign pend_tgt  = pend_pc_reg & ALIGN_MASK;

`ifdef IF_MISALIGN_CHECK_EN
  assign redir_bad   = |redirect_pc[1:0];
  assign pend_bad    = |pend_pc_reg[1:0];
  assign fetch_fault = (state_reg == FAULT);
`else
  assign redir_bad = 1'b0;
  assign pend_bad  = 1'b0;
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC & ALIGN_MASK;
      ir_reg       <= '0;
      pc_reg       <= '0;
      pend_reg     <= 1'b0;
      pend_pc_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      ir_reg       <= ir_next;
      pc_reg       <= pc_next;
      pend_reg     <= pend_next;
      pend_pc_reg  <= pend_pc_next;
    end
  end

  // Next-state and datapath update logic; outputs are decoded from state_reg
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    ir_next       = ir_reg;
    pc_next       = pc_reg;
    pend_next     = pend_reg;
    pend_pc_next  = pend_pc_reg;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        if (redirect_en) begin
          if (redir_bad) state_next = FAULT;
          else           fetch_pc_next = redir_tgt;
        end
      end

      FETCH: begin
        if (imem_ack) begin
          if (redirect_en) begin
            // Word returned for a path that is being abandoned
            pend_next = 1'b0;
            if (redir_bad) state_next = FAULT;
            else           fetch_pc_next = redir_tgt;
          end else if (pend_reg) begin
            pend_next = 1'b0;
            if (pend_bad) state_next = FAULT;
            else          fetch_pc_next = pend_tgt;
          end else begin
            ir_next       = imem_rdata;
            pc_next       = fetch_pc_reg;
            fetch_pc_next = fetch_pc_reg + PC_STEP;
            state_next    = FULL;
          end
        end else if (redirect_en) begin
          // Keep the current request stable; apply the target after its ack
          pend_next    = 1'b1;
          pend_pc_next = redirect_pc;
        end
      end

      FULL: begin
        if (redirect_en) begin
          if (redir_bad) state_next = FAULT;
          else begin
            fetch_pc_next = redir_tgt;
            state_next    = FETCH;
          end
        end else if (ir_ready) begin
          state_next = FETCH;
        end
      end

      FAULT: begin
        if (redirect_en && !redir_bad) begin
          fetch_pc_next = redir_tgt;
          state_next    = FETCH;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign imem_req  = (state_reg == FETCH);
  assign imem_addr = fetch_pc_reg;
  assign ir_valid  = (state_reg == FULL);
  assign pc        = pc_reg;
  assign pc_plus4  = pc_reg + PC_STEP;

  ir_fields u_ir_fields (
    .ir     (ir_reg),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imme   (imme),
    .target (target)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset values, single-cycle and delayed acks,
// FULL hold, redirect while fetching, redirect vs ir_ready priority, PC wrap,
// low-bit handling of redirect targets and reset mid-request.
module tb_if_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        ir_ready;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imme;
  logic [25:0] target;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ir_ready    (ir_ready),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imme        (imme),
    .target      (target)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    ir_ready    = 1'b0;
    tick();
    tick();

    // Reset state
    $display("txn reset");
    check("rst_ir_valid", 32'(ir_valid), 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_imme", 32'(imme), 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
    check("rst_fault", 32'(fetch_fault), 32'h0);
`endif

    // IDLE -> FETCH, first request at RESET_PC
    rst_n = 1'b1;
    tick();
    $display("txn first request addr=%h", imem_addr);
    check("t1_req", 32'(imem_req), 32'h1);
    check("t1_addr", imem_addr, 32'h0);
    check("t1_valid_pre", 32'(ir_valid), 32'h0);

    // Ack in first FETCH cycle
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ack = 1'b0;
    $display("txn fetch1 pc=%h ir_valid=%0b opcode=%h", pc, ir_valid, opcode);
    check("t1_valid", 32'(ir_valid), 32'h1);
    check("t1_opcode", 32'(opcode), 32'h08);
    check("t1_rt", 32'(rt), 32'h08);
    check("t1_rs", 32'(rs), 32'h00);
    check("t1_imme", 32'(imme), 32'h0005);
    check("t1_pc", pc, 32'h0);
    check("t1_pc_plus4", pc_plus4, 32'h4);
    check("t1_req_full", 32'(imem_req), 32'h0);

    // Hold in FULL for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", 32'(ir_valid), 32'h1);
      check("t2_hold_req", 32'(imem_req), 32'h0);
      check("t2_hold_imme", 32'(imme), 32'h0005);
    end
    $display("txn hold done imme=%h", imme);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    $display("txn consume next addr=%h", imem_addr);
    check("t2_valid_drop", 32'(ir_valid), 32'h0);
    check("t2_req", 32'(imem_req), 32'h1);
    check("t2_addr", imem_addr, 32'h4);
    check("t2_keep_opcode", 32'(opcode), 32'h08);

    // Ack delayed 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_wait_addr", imem_addr, 32'h4);
      check("t3_wait_req", 32'(imem_req), 32'h1);
      check("t3_wait_valid", 32'(ir_valid), 32'h0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h012A_4020;
    tick();
    imem_ack = 1'b0;
    $display("txn fetch2 pc=%h rs=%0d rt=%0d rd=%0d funct=%h", pc, rs, rt, rd, funct);
    check("t3_valid", 32'(ir_valid), 32'h1);
    check("t3_pc", pc, 32'h4);
    check("t3_pc_plus4", pc_plus4, 32'h8);
    check("t3_opcode", 32'(opcode), 32'h00);
    check("t3_rs", 32'(rs), 32'd9);
    check("t3_rt", 32'(rt), 32'd10);
    check("t3_rd", 32'(rd), 32'd8);
    check("t3_shamt", 32'(shamt), 32'd0);
    check("t3_funct", 32'(funct), 32'h20);
    check("t3_target", 32'(target), 32'h012A_4020);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("t3_next_addr", imem_addr, 32'h8);

    // Redirect during FETCH, ack two cycles later
    redirect_en = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_en = 1'b0;
    check("t4_addr_hold0", imem_addr, 32'h8);
    check("t4_req_hold0", 32'(imem_req), 32'h1);
    tick();
    check("t4_addr_hold1", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    $display("txn redirect-pending discard addr=%h ir_valid=%0b", imem_addr, ir_valid);
    check("t4_valid", 32'(ir_valid), 32'h0);
    check("t4_addr_new", imem_addr, 32'h40);
    check("t4_req", 32'(imem_req), 32'h1);
    check("t4_ir_kept", 32'(imme), 32'h4020);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    tick();
    imem_ack = 1'b0;
    $display("txn fetch3 pc=%h target=%h", pc, target);
    check("t4_valid2", 32'(ir_valid), 32'h1);
    check("t4_pc", pc, 32'h40);
    check("t4_pc_plus4", pc_plus4, 32'h44);
    check("t4_opcode", 32'(opcode), 32'h02);
    check("t4_target", 32'(target), 32'h10);

    // Redirect and ir_ready together in FULL: redirect wins
    redirect_en = 1'b1; redirect_pc = 32'h100; ir_ready = 1'b1;
    tick();
    redirect_en = 1'b0; ir_ready = 1'b0;
    $display("txn redirect-vs-ready addr=%h", imem_addr);
    check("t5_valid", 32'(ir_valid), 32'h0);
    check("t5_addr", imem_addr, 32'h100);

    // Redirect coinciding with ack: word dropped, new target fetched
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    redirect_en = 1'b0;
    check("t6_valid", 32'(ir_valid), 32'h0);
    check("t6_addr", imem_addr, 32'hFFFF_FFFC);
    check("t6_pc_kept", pc, 32'h40);
    imem_rdata = 32'h3C01_1234;
    tick();
    imem_ack = 1'b0;
    $display("txn wrap fetch pc=%h pc_plus4=%h", pc, pc_plus4);
    check("t6_valid2", 32'(ir_valid), 32'h1);
    check("t6_pc", pc, 32'hFFFF_FFFC);
    check("t6_pc_plus4", pc_plus4, 32'h0);
    check("t6_opcode", 32'(opcode), 32'h0F);
    check("t6_rt", 32'(rt), 32'd1);
    check("t6_imme", 32'(imme), 32'h1234);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("t6_wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect target
    redirect_en = 1'b1; redirect_pc = 32'h42;
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    redirect_en = 1'b0; imem_ack = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    $display("txn misaligned redirect fault=%0b req=%0b", fetch_fault, imem_req);
    check("t7_fault", 32'(fetch_fault), 32'h1);
    check("t7_req", 32'(imem_req), 32'h0);
    check("t7_valid", 32'(ir_valid), 32'h0);
    tick();
    check("t7_fault_stay", 32'(fetch_fault), 32'h1);
    redirect_en = 1'b1; redirect_pc = 32'h44;
    tick();
    redirect_en = 1'b0;
    $display("txn aligned redirect fault=%0b addr=%h", fetch_fault, imem_addr);
    check("t7_fault_clr", 32'(fetch_fault), 32'h0);
    check("t7_req2", 32'(imem_req), 32'h1);
    check("t7_addr2", imem_addr, 32'h44);
`else
    $display("txn misaligned redirect addr=%h", imem_addr);
    check("t7_addr_forced", imem_addr, 32'h40);
    check("t7_req", 32'(imem_req), 32'h1);
    check("t7_valid", 32'(ir_valid), 32'h0);
`endif

    // Reset while a request is outstanding
    rst_n = 1'b0;
    tick();
    $display("txn reset mid-request req=%0b", imem_req);
    check("t8_req", 32'(imem_req), 32'h0);
    check("t8_valid", 32'(ir_valid), 32'h0);
    check("t8_pc", pc, 32'h0);
    check("t8_opcode", 32'(opcode), 32'h0);
    // Late ack and a redirect in IDLE: ack ignored, redirect loads fetch PC
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_en = 1'b0; imem_ack = 1'b0;
    $display("txn idle redirect addr=%h ir_valid=%0b", imem_addr, ir_valid);
    check("t8_idle_valid", 32'(ir_valid), 32'h0);
    check("t8_idle_req", 32'(imem_req), 32'h1);
    check("t8_idle_addr", imem_addr, 32'h200);
    check("t8_idle_imme", 32'(imme), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
